// File: rtl/lightpix_pkt_pkg.sv
// lightpix_pkt_pkg: LightPix packet field layout and collector state encoding.
package lightpix_pkt_pkg;
  typedef enum logic [1:0] {DATA = 2'd0, TEST = 2'd1, CONFIG_WRITE = 2'd2, CONFIG_READ = 2'd3} packet_declare_t;
  typedef enum logic [2:0] {S_IDLE, S_ULD, S_CAP, S_PUSH, S_WAIT} rx_state_t;
  localparam int CHIP_ID_LSB = 2;
  localparam int CHIP_ID_W = 8;
  localparam int CHANNEL_LSB = 10;
  localparam int CHANNEL_W = 6;
  localparam int TIMESTAMP_LSB = 16;
  localparam int TIMESTAMP_W = 32;
  localparam int DATA_WORD_LSB = 48;
  localparam int DATA_WORD_W = 8;
  localparam int TRIGGER_LSB = 56;
  localparam int TRIGGER_W = 2;
  localparam int REG_ADDR_LSB = 10;
  localparam int REG_ADDR_W = 8;
  localparam int REG_DATA_LSB = 18;
  localparam int REG_DATA_W = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through head.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop, w_push;
  assign w_pop = pop & !empty;
  assign w_push = push & (!full | w_pop);
  assign full = r_count == CW'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout = r_mem[r_rd];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/rx_packet_collector.sv
// rx_packet_collector: unloads uart_rx packets into a FIFO with per-type statistics.
module rx_packet_collector
  import lightpix_pkt_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_empty,
  input  logic [WIDTH-2:0]                rx_data,
  input  logic                            parity_error,
  output logic                            uld_rx_data,
  input  logic                            drop_parity_err,
  input  logic                            clear_stats,
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [WIDTH-2:0]                pkt_data,
  output logic                            pkt_parity_err,
  output logic [1:0]                      pkt_type,
  output logic [7:0]                      pkt_chip_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  output logic [CNT_WIDTH-1:0]            data_cnt,
  output logic [CNT_WIDTH-1:0]            test_cnt,
  output logic [CNT_WIDTH-1:0]            cfg_wr_cnt,
  output logic [CNT_WIDTH-1:0]            cfg_rd_cnt,
  output logic [CNT_WIDTH-1:0]            parity_err_cnt,
  output logic [CNT_WIDTH-1:0]            drop_cnt
);
  rx_state_t r_state;
  logic [WIDTH-2:0] r_data;
  logic r_perr, r_uld, r_ovf;
  logic [CNT_WIDTH-1:0] r_cnt [6];
  logic [WIDTH-1:0] w_head;
  logic w_in_push, w_drop_par, w_push, w_pop, w_full, w_empty, w_ovf;
  logic [5:0] w_inc;
  packet_declare_t w_type;
  assign w_in_push = r_state == S_PUSH;
  assign w_drop_par = r_perr & drop_parity_err;
  assign w_push = w_in_push & !w_drop_par;
  assign w_pop = pkt_valid & pkt_ready;
  assign w_ovf = w_push & w_full & !w_pop;
  assign w_type = packet_declare_t'(r_data[1:0]);
  // A full-FIFO drop still counts its type; only a parity drop skips it.
  assign w_inc = {(w_in_push & w_drop_par) | w_ovf, w_in_push & r_perr,
                  w_push & (w_type == CONFIG_READ), w_push & (w_type == CONFIG_WRITE),
                  w_push & (w_type == TEST), w_push & (w_type == DATA)};
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_uld <= 1'b0;
      r_data <= '0;
      r_perr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (!rx_empty) begin
          r_state <= S_ULD;
          r_uld <= 1'b1;
        end
        S_ULD: r_state <= S_CAP;
        S_CAP: begin
          r_state <= S_PUSH;
          r_uld <= 1'b0;
          r_data <= rx_data;
          r_perr <= parity_error;
        end
        S_PUSH: r_state <= S_WAIT;
        S_WAIT: if (rx_empty) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (reset || clear_stats) begin
      for (int i = 0; i < 6; i++) r_cnt[i] <= '0;
      r_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++)
        if (w_inc[i] && !(&r_cnt[i])) r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      if (w_ovf) r_ovf <= 1'b1;
    end
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(w_push), .pop(w_pop), .din({r_perr, r_data}),
    .dout(w_head), .full(w_full), .empty(w_empty), .count(fifo_count)
  );
  assign uld_rx_data = r_uld;
  assign pkt_valid = !w_empty;
  assign pkt_data = pkt_valid ? w_head[WIDTH-2:0] : '0;
  assign pkt_parity_err = pkt_valid & w_head[WIDTH-1];
  assign pkt_type = pkt_data[1:0];
  assign pkt_chip_id = pkt_data[CHIP_ID_LSB +: CHIP_ID_W];
  assign overflow = r_ovf;
  assign data_cnt = r_cnt[0];
  assign test_cnt = r_cnt[1];
  assign cfg_wr_cnt = r_cnt[2];
  assign cfg_rd_cnt = r_cnt[3];
  assign parity_err_cnt = r_cnt[4];
  assign drop_cnt = r_cnt[5];
endmodule

// File: tb/tb_rx_packet_collector.sv
// tb_rx_packet_collector: directed checks of unload handshake, FIFO, counters and reset.
module tb_rx_packet_collector;
  logic clk = 0, reset = 1, rx_empty = 1, parity_error = 0, drop_parity_err = 0, clear_stats = 0, pkt_ready = 0;
  logic [62:0] rx_data = '0;
  logic uld_rx_data, pkt_valid, pkt_parity_err, overflow;
  logic [62:0] pkt_data;
  logic [1:0] pkt_type;
  logic [7:0] pkt_chip_id;
  logic [4:0] fifo_count;
  logic [15:0] data_cnt, test_cnt, cfg_wr_cnt, cfg_rd_cnt, parity_err_cnt, drop_cnt;
  logic s_uld, s_valid, s_perr, s_ovf;
  logic [62:0] s_data;
  logic [1:0] s_type;
  logic [7:0] s_chip;
  logic [4:0] s_count;
  logic [1:0] s_data_cnt, s_test_cnt, s_cfg_wr_cnt, s_cfg_rd_cnt, s_parity_err_cnt, s_drop_cnt;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  rx_packet_collector dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .parity_error(parity_error),
    .uld_rx_data(uld_rx_data), .drop_parity_err(drop_parity_err), .clear_stats(clear_stats),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .pkt_parity_err(pkt_parity_err),
    .pkt_type(pkt_type), .pkt_chip_id(pkt_chip_id), .fifo_count(fifo_count), .overflow(overflow),
    .data_cnt(data_cnt), .test_cnt(test_cnt), .cfg_wr_cnt(cfg_wr_cnt), .cfg_rd_cnt(cfg_rd_cnt),
    .parity_err_cnt(parity_err_cnt), .drop_cnt(drop_cnt)
  );

  rx_packet_collector #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data), .parity_error(parity_error),
    .uld_rx_data(s_uld), .drop_parity_err(drop_parity_err), .clear_stats(clear_stats),
    .pkt_valid(s_valid), .pkt_ready(pkt_ready), .pkt_data(s_data), .pkt_parity_err(s_perr),
    .pkt_type(s_type), .pkt_chip_id(s_chip), .fifo_count(s_count), .overflow(s_ovf),
    .data_cnt(s_data_cnt), .test_cnt(s_test_cnt), .cfg_wr_cnt(s_cfg_wr_cnt), .cfg_rd_cnt(s_cfg_rd_cnt),
    .parity_err_cnt(s_parity_err_cnt), .drop_cnt(s_drop_cnt)
  );

  task automatic send(input logic [62:0] d, input logic pe);
    @(negedge clk); rx_empty = 0; rx_data = d; parity_error = pe;
    @(posedge clk);
    @(negedge clk); rx_empty = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (uld_rx_data !== 1'b0) begin n_fail++; $display("FAIL reset_uld: got %b want 0", uld_rx_data); end
    n_tests++; if (pkt_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_fifo: valid %b count %0d want 0 0", pkt_valid, fifo_count); end
    n_tests++; if (pkt_data !== 63'd0 || pkt_type !== 2'd0 || pkt_chip_id !== 8'd0 || pkt_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_head: data %h type %0d chip %0d perr %b want 0", pkt_data, pkt_type, pkt_chip_id, pkt_parity_err); end
    n_tests++; if (data_cnt !== 16'd0 || drop_cnt !== 16'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_stats: data %0d drop %0d ovf %b want 0", data_cnt, drop_cnt, overflow); end
    reset = 0;
  endtask

  task automatic test_single;
    @(negedge clk); rx_empty = 0; rx_data = 63'h0000_0012_3456_7840; parity_error = 0;
    @(posedge clk); #1;
    n_tests++; if (uld_rx_data !== 1'b1) begin n_fail++; $display("FAIL single_uld1: got %b want 1", uld_rx_data); end
    @(negedge clk); rx_empty = 1;
    @(posedge clk); #1;
    n_tests++; if (uld_rx_data !== 1'b1) begin n_fail++; $display("FAIL single_uld2: got %b want 1", uld_rx_data); end
    @(posedge clk); #1;
    n_tests++; if (uld_rx_data !== 1'b0 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL single_uld3: uld %b valid %b want 0 0", uld_rx_data, pkt_valid); end
    @(posedge clk); #1;
    n_tests++; if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", pkt_valid); end
    n_tests++; if (pkt_chip_id !== 8'd16 || pkt_type !== 2'd0) begin n_fail++; $display("FAIL single_fields: chip %0d type %0d want 16 0", pkt_chip_id, pkt_type); end
    n_tests++; if (pkt_data !== 63'h0000_0012_3456_7840 || data_cnt !== 16'd1) begin n_fail++; $display("FAIL single_data: data %h cnt %0d want 1234567840 1", pkt_data, data_cnt); end
    @(posedge clk);
    @(negedge clk); pkt_ready = 1;
    @(negedge clk); pkt_ready = 0;
    n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL single_pop: count %0d want 0", fifo_count); end
  endtask

  task automatic test_type_mix;
    pkt_ready = 1;
    send(63'h41, 0);
    send(63'h42, 0);
    send(63'h43, 0);
    pkt_ready = 0;
    n_tests++; if (test_cnt !== 16'd1 || cfg_wr_cnt !== 16'd1 || cfg_rd_cnt !== 16'd1 || data_cnt !== 16'd1) begin n_fail++; $display("FAIL type_mix_cnt: test %0d wr %0d rd %0d data %0d want 1 1 1 1", test_cnt, cfg_wr_cnt, cfg_rd_cnt, data_cnt); end
    n_tests++; if (fifo_count !== 5'd0 || pkt_valid !== 1'b0) begin n_fail++; $display("FAIL type_mix_empty: count %0d valid %b want 0 0", fifo_count, pkt_valid); end
  endtask

  task automatic test_parity;
    send(63'h44, 1);
    n_tests++; if (pkt_valid !== 1'b1 || pkt_parity_err !== 1'b1 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL parity_keep: valid %b perr %b count %0d want 1 1 1", pkt_valid, pkt_parity_err, fifo_count); end
    n_tests++; if (parity_err_cnt !== 16'd1 || data_cnt !== 16'd2 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL parity_keep_cnt: perr %0d data %0d drop %0d want 1 2 0", parity_err_cnt, data_cnt, drop_cnt); end
    pkt_ready = 1;
    @(negedge clk); pkt_ready = 0; drop_parity_err = 1;
    send(63'h44, 1);
    drop_parity_err = 0;
    n_tests++; if (pkt_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL parity_drop: valid %b count %0d want 0 0", pkt_valid, fifo_count); end
    n_tests++; if (drop_cnt !== 16'd1 || parity_err_cnt !== 16'd2 || data_cnt !== 16'd2 || overflow !== 1'b0) begin n_fail++; $display("FAIL parity_drop_cnt: drop %0d perr %0d data %0d ovf %b want 1 2 2 0", drop_cnt, parity_err_cnt, data_cnt, overflow); end
  endtask

  task automatic test_overflow;
    logic [62:0] exp;
    @(negedge clk); clear_stats = 1;
    @(negedge clk); clear_stats = 0;
    n_tests++; if (drop_cnt !== 16'd0 || parity_err_cnt !== 16'd0 || test_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_stats: drop %0d perr %0d test %0d want 0", drop_cnt, parity_err_cnt, test_cnt); end
    for (int i = 0; i < 17; i++) send(63'h100 + 63'(i), 0);
    n_tests++; if (fifo_count !== 5'd16 || drop_cnt !== 16'd1 || overflow !== 1'b1) begin n_fail++; $display("FAIL overflow: count %0d drop %0d ovf %b want 16 1 1", fifo_count, drop_cnt, overflow); end
    n_tests++; if (data_cnt !== 16'd5 || pkt_data !== 63'h100) begin n_fail++; $display("FAIL overflow_type: data %0d head %h want 5 100", data_cnt, pkt_data); end
    @(negedge clk); rx_empty = 0; rx_data = 63'h200;
    @(posedge clk);
    @(negedge clk); rx_empty = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); pkt_ready = 1;
    @(posedge clk);
    @(negedge clk); pkt_ready = 0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (fifo_count !== 5'd16 || drop_cnt !== 16'd1 || data_cnt !== 16'd6) begin n_fail++; $display("FAIL full_push_pop: count %0d drop %0d data %0d want 16 1 6", fifo_count, drop_cnt, data_cnt); end
    pkt_ready = 1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 63'h101 + 63'(i) : 63'h200;
      n_tests++; if (pkt_valid !== 1'b1 || pkt_data !== exp) begin n_fail++; $display("FAIL drain_order[%0d]: valid %b data %h want 1 %h", i, pkt_valid, pkt_data, exp); end
      @(negedge clk);
    end
    pkt_ready = 0;
    n_tests++; if (fifo_count !== 5'd0 || pkt_valid !== 1'b0 || pkt_data !== 63'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL drain_empty: count %0d valid %b data %h ovf %b want 0 0 0 1", fifo_count, pkt_valid, pkt_data, overflow); end
  endtask

  task automatic test_clear_coincident;
    @(negedge clk); rx_empty = 0; rx_data = 63'h40;
    @(posedge clk);
    @(negedge clk); rx_empty = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); clear_stats = 1;
    @(posedge clk);
    @(negedge clk); clear_stats = 0;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (data_cnt !== 16'd0 || overflow !== 1'b0 || drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clear_coincident: data %0d ovf %b drop %0d want 0 0 0", data_cnt, overflow, drop_cnt); end
    n_tests++; if (fifo_count !== 5'd1 || pkt_data !== 63'h40) begin n_fail++; $display("FAIL clear_keeps_fifo: count %0d head %h want 1 40", fifo_count, pkt_data); end
  endtask

  task automatic test_reset_mid_cap;
    @(negedge clk); rx_empty = 0; rx_data = 63'h48;
    @(posedge clk);
    @(negedge clk); rx_empty = 1;
    @(posedge clk);
    @(negedge clk);
    n_tests++; if (uld_rx_data !== 1'b1) begin n_fail++; $display("FAIL cap_uld: got %b want 1", uld_rx_data); end
    reset = 1;
    @(posedge clk); #1;
    n_tests++; if (uld_rx_data !== 1'b0 || pkt_valid !== 1'b0 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_mid_cap: uld %b valid %b count %0d want 0 0 0", uld_rx_data, pkt_valid, fifo_count); end
    @(negedge clk); reset = 0;
    repeat (3) @(negedge clk);
    n_tests++; if (pkt_valid !== 1'b0 || uld_rx_data !== 1'b0) begin n_fail++; $display("FAIL reset_discard: valid %b uld %b want 0 0", pkt_valid, uld_rx_data); end
  endtask

  task automatic test_saturation;
    pkt_ready = 1;
    for (int i = 0; i < 5; i++) send(63'h40, 0);
    pkt_ready = 0;
    n_tests++; if (s_data_cnt !== 2'd3) begin n_fail++; $display("FAIL saturate: got %0d want 3", s_data_cnt); end
    n_tests++; if (data_cnt !== 16'd5) begin n_fail++; $display("FAIL wide_count: got %0d want 5", data_cnt); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_type_mix;
    test_parity;
    test_overflow;
    test_clear_coincident;
    test_reset_mid_cap;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
